// File: rtl/io_pkg.sv
// Shared types and constants for the io_bridge peripherals: interrupt controller
// FSM states, register offsets and the vector address helper.
package io_pkg;

  localparam int unsigned INTC_DATA_W          = 16;
  localparam int unsigned INTC_IDX_W           = 3;
  localparam int unsigned INTC_STATUS_BUSY_BIT = 15;

  typedef enum logic [1:0] {
    INTC_IDLE    = 2'd0,
    INTC_REQ     = 2'd1,
    INTC_SERVICE = 2'd2
  } intc_state_e;

  localparam logic [1:0] INTC_PENDING = 2'd0;
  localparam logic [1:0] INTC_MASK    = 2'd1;
  localparam logic [1:0] INTC_CTRL    = 2'd2;
  localparam logic [1:0] INTC_STATUS  = 2'd3;

  // Handler address of source idx: vectors are two words apart.
  function automatic logic [INTC_DATA_W-1:0] intc_vector(
    input logic [INTC_DATA_W-1:0] base,
    input logic [INTC_IDX_W-1:0]  idx
  );
    return base + {12'b0, idx, 1'b0};
  endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Per-bit two-flop synchronizer followed by a rising-edge detector.
module irq_sync_edge #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] irq,
  output logic [W-1:0] rise_c
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;
  logic [W-1:0] prev_q;

  // Synchronizer chain plus one history stage for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      meta_q <= irq;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rise_c = sync_q & ~prev_q;

endmodule

// File: rtl/int_controller.sv
// Prioritized interrupt controller: pending/mask/GIE registers on the data bus,
// lowest-index-wins arbitration, one request in service at a time.
module int_controller
  import io_pkg::*;
#(
  parameter int unsigned N_SRC       = 4,
  parameter logic [15:0] REG_BASE    = 16'hFF10,
  parameter logic [15:0] VECTOR_BASE = 16'h0010
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] irq,
  input  logic [15:0]      d_addr,
  input  logic [15:0]      d_wdata,
  input  logic             io_read,
  input  logic             io_write,
  output logic [15:0]      d_rdata,
  output logic             interrupt,
  output logic [15:0]      int_vector,
  input  logic             int_ack,
  input  logic             reti
);

  localparam int unsigned DW    = INTC_DATA_W;
  localparam int unsigned IDX_W = INTC_IDX_W;

  logic [N_SRC-1:0] rise_c;
  logic [N_SRC-1:0] pending_q;
  logic [N_SRC-1:0] pending_d;
  logic [N_SRC-1:0] mask_q;
  logic [N_SRC-1:0] elig_c;
  logic [N_SRC-1:0] clr_c;
  logic             gie_q;

  intc_state_e      state_q;
  intc_state_e      state_d;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] idx_d;
  logic [IDX_W-1:0] win_c;
  logic [DW-1:0]    vec_d;
  logic             int_d;

  logic [DW-1:0]    off_c;
  logic             hit_c;
  logic [1:0]       reg_sel_c;
  logic             wr_pend_c;
  logic             wr_mask_c;
  logic             wr_ctrl_c;
  logic [DW-1:0]    status_c;
  logic [DW-1:0]    rdata_d;
  logic             unused_wdata_c;

  irq_sync_edge #(
    .W(N_SRC)
  ) u_sync (
    .clk   (clk),
    .rst   (rst),
    .irq   (irq),
    .rise_c(rise_c)
  );

  // Register decode: a window of four words starting at REG_BASE.
  assign off_c     = d_addr - REG_BASE;
  assign hit_c     = (off_c < 16'd4);
  assign reg_sel_c = off_c[1:0];
  assign wr_pend_c = io_write && hit_c && (reg_sel_c == INTC_PENDING);
  assign wr_mask_c = io_write && hit_c && (reg_sel_c == INTC_MASK);
  assign wr_ctrl_c = io_write && hit_c && (reg_sel_c == INTC_CTRL);

  assign unused_wdata_c = ^d_wdata[DW-1:N_SRC];

  assign elig_c = pending_q & mask_q & {N_SRC{gie_q}};

  // Priority encoder: lowest eligible index wins.
  always_comb begin
    win_c = '0;
    for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
      if (elig_c[i]) win_c = IDX_W'(i);
    end
  end

  // Next state, winner latch and request output.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    vec_d   = int_vector;
    int_d   = 1'b0;
    case (state_q)
      INTC_IDLE: begin
        if (|elig_c) begin
          state_d = INTC_REQ;
          idx_d   = win_c;
          vec_d   = intc_vector(VECTOR_BASE, win_c);
        end
      end
      INTC_REQ: begin
        if (int_ack) state_d = INTC_SERVICE;
      end
      INTC_SERVICE: begin
        if (reti) state_d = INTC_IDLE;
      end
      default: state_d = INTC_IDLE;
    endcase
    int_d = (state_d == INTC_REQ);
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= INTC_IDLE;
    else     state_q <= state_d;
  end

  // Registered CPU-facing outputs and the active source index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      interrupt  <= 1'b0;
      int_vector <= '0;
      idx_q      <= '0;
    end else begin
      interrupt  <= int_d;
      int_vector <= vec_d;
      idx_q      <= idx_d;
    end
  end

  // Pending clears from software W1C and from the CPU acknowledge; new edges win.
  always_comb begin
    clr_c = '0;
    if (wr_pend_c) clr_c = d_wdata[N_SRC-1:0];
    if ((state_q == INTC_REQ) && int_ack) clr_c = clr_c | (N_SRC'(1) << idx_q);
    pending_d = (pending_q & ~clr_c) | rise_c;
  end

  // STATUS shows the busy flag and active index only while a source is in service.
  always_comb begin
    status_c = '0;
    if (state_q == INTC_SERVICE) begin
      status_c[INTC_STATUS_BUSY_BIT] = 1'b1;
      status_c[IDX_W-1:0]            = idx_q;
    end
  end

  // Read mux; zero when not reading or outside the register window.
  always_comb begin
    rdata_d = '0;
    if (io_read && hit_c) begin
      case (reg_sel_c)
        INTC_PENDING: rdata_d = DW'(pending_q);
        INTC_MASK:    rdata_d = DW'(mask_q);
        INTC_CTRL:    rdata_d = DW'(gie_q);
        INTC_STATUS:  rdata_d = status_c;
        default:      rdata_d = '0;
      endcase
    end
  end

  // Software-visible registers and registered read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= '0;
      mask_q    <= '0;
      gie_q     <= 1'b0;
      d_rdata   <= '0;
    end else begin
      pending_q <= pending_d;
      if (wr_mask_c) mask_q <= d_wdata[N_SRC-1:0];
      if (wr_ctrl_c) gie_q  <= d_wdata[0];
      d_rdata <= rdata_d;
    end
  end

endmodule

// File: tb/tb_int_controller.sv
// Bench for int_controller: register table, directed corner sequences and a
// randomized run, all cross-checked against a cycle reference model.
module tb_int_controller;

  localparam logic [15:0] RB = 16'hFF10;
  localparam logic [15:0] VB = 16'h0010;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  irq;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic        io_read;
  logic        io_write;
  logic [15:0] d_rdata;
  logic        interrupt;
  logic [15:0] int_vector;
  logic        int_ack;
  logic        reti;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  int_controller #(
    .N_SRC      (4),
    .REG_BASE   (RB),
    .VECTOR_BASE(VB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .irq       (irq),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .io_read   (io_read),
    .io_write  (io_write),
    .d_rdata   (d_rdata),
    .interrupt (interrupt),
    .int_vector(int_vector),
    .int_ack   (int_ack),
    .reti      (reti)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lowest(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return 0;
  endfunction

  // Reference model: mode 0 idle, 1 requesting, 2 in service.
  logic [3:0]  m_pend, m_mask;
  logic        m_gie;
  int          m_mode, m_idx;
  logic [15:0] m_vec, m_rd;
  logic [3:0]  smp [3];

  always @(posedge clk) begin : ref_model
    logic [3:0]  edge_v, clr, elig;
    logic [15:0] off, val;
    if (rst) begin
      m_pend = '0; m_mask = '0; m_gie = 1'b0;
      m_mode = 0;  m_idx = 0;   m_vec = '0; m_rd = '0;
      for (int i = 0; i < 3; i++) smp[i] = '0;
    end else begin
      // An irq edge becomes visible two samples after it is first seen.
      edge_v = smp[1] & ~smp[2];
      smp[2] = smp[1]; smp[1] = smp[0]; smp[0] = irq;
      off = d_addr - RB;
      case (off)
        16'd0:   val = {12'h0, m_pend};
        16'd1:   val = {12'h0, m_mask};
        16'd2:   val = {15'h0, m_gie};
        16'd3:   val = (m_mode == 2) ? (16'h8000 | 16'(m_idx)) : 16'h0;
        default: val = 16'h0;
      endcase
      m_rd = io_read ? val : 16'h0;
      elig = m_pend & m_mask & {4{m_gie}};
      clr  = (io_write && off == 16'd0) ? d_wdata[3:0] : 4'h0;
      if (m_mode == 0 && elig != 4'h0) begin
        m_idx  = lowest(elig);
        m_mode = 1;
        m_vec  = VB + 16'(2 * m_idx);
      end else if (m_mode == 1 && int_ack) begin
        m_mode = 2;
        clr[m_idx] = 1'b1;
      end else if (m_mode == 2 && reti) begin
        m_mode = 0;
      end
      m_pend = (m_pend & ~clr) | edge_v;
      if (io_write && off == 16'd1) m_mask = d_wdata[3:0];
      if (io_write && off == 16'd2) m_gie  = d_wdata[0];
    end
    #1;
    check("model_interrupt", {15'h0, interrupt}, (m_mode == 1) ? 16'd1 : 16'd0);
    check("model_vector", int_vector, m_vec);
    check("model_rdata", d_rdata, m_rd);
  end

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    io_write = 1'b1; d_addr = a; d_wdata = d;
    @(negedge clk);
    io_write = 1'b0;
  endtask

  task automatic rd(input string name, input logic [15:0] a, input logic [15:0] exp);
    io_read = 1'b1; d_addr = a;
    @(negedge clk);
    io_read = 1'b0;
    check(name, d_rdata, exp);
  endtask

  task automatic pulse_ack();
    int_ack = 1'b1; @(negedge clk); int_ack = 1'b0;
  endtask

  task automatic pulse_reti();
    reti = 1'b1; @(negedge clk); reti = 1'b0;
  endtask

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data;
    logic [15:0] exp;
  } reg_vec_t;

  reg_vec_t tbl [16];

  initial begin
    rst = 1'b1; irq = '0; d_addr = '0; d_wdata = '0;
    io_read = 1'b0; io_write = 1'b0; int_ack = 1'b0; reti = 1'b0;
    #1;
    check("reset_interrupt", {15'h0, interrupt}, 16'd0);
    check("reset_vector", int_vector, 16'h0000);
    check("reset_rdata", d_rdata, 16'h0000);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Register access table: write or read-and-compare.
    tbl[0]  = '{1'b1, RB + 16'd1, 16'hFFFF, 16'h0000};
    tbl[1]  = '{1'b0, RB + 16'd1, 16'h0000, 16'h000F};
    tbl[2]  = '{1'b1, RB + 16'd2, 16'h0003, 16'h0000};
    tbl[3]  = '{1'b0, RB + 16'd2, 16'h0000, 16'h0001};
    tbl[4]  = '{1'b1, RB + 16'd3, 16'hFFFF, 16'h0000};
    tbl[5]  = '{1'b0, RB + 16'd3, 16'h0000, 16'h0000};
    tbl[6]  = '{1'b1, 16'hFF15,   16'h0000, 16'h0000};
    tbl[7]  = '{1'b0, RB + 16'd1, 16'h0000, 16'h000F};
    tbl[8]  = '{1'b1, 16'hFF0E,   16'h0000, 16'h0000};
    tbl[9]  = '{1'b0, RB + 16'd2, 16'h0000, 16'h0001};
    tbl[10] = '{1'b0, 16'hFF15,   16'h0000, 16'h0000};
    tbl[11] = '{1'b0, 16'hFF0E,   16'h0000, 16'h0000};
    tbl[12] = '{1'b0, RB,         16'h0000, 16'h0000};
    tbl[13] = '{1'b1, RB + 16'd1, 16'h0000, 16'h0000};
    tbl[14] = '{1'b1, RB + 16'd2, 16'h0000, 16'h0000};
    tbl[15] = '{1'b0, RB + 16'd1, 16'h0000, 16'h0000};
    for (int i = 0; i < 16; i++) begin
      if (tbl[i].wr) wr(tbl[i].addr, tbl[i].data);
      else           rd($sformatf("reg_vec%0d", i), tbl[i].addr, tbl[i].exp);
    end

    // Basic request on source 2.
    wr(RB + 16'd1, 16'h0004);
    wr(RB + 16'd2, 16'h0001);
    irq = 4'b0100;
    repeat (3) @(negedge clk);
    check("basic_not_yet", {15'h0, interrupt}, 16'd0);
    @(negedge clk);
    check("basic_interrupt", {15'h0, interrupt}, 16'd1);
    check("basic_vector", int_vector, 16'h0014);
    irq = '0;
    pulse_ack();
    check("basic_ack_drop", {15'h0, interrupt}, 16'd0);
    rd("basic_pending", RB, 16'h0000);
    rd("basic_status", RB + 16'd3, 16'h8002);
    pulse_reti();
    rd("basic_status_after_reti", RB + 16'd3, 16'h0000);

    // Priority between simultaneous edges on sources 3 and 1.
    wr(RB + 16'd1, 16'h000F);
    irq = 4'b1010;
    repeat (4) @(negedge clk);
    check("prio_first_vector", int_vector, 16'h0012);
    irq = '0;
    pulse_ack();
    pulse_reti();
    check("prio_gap", {15'h0, interrupt}, 16'd0);
    @(negedge clk);
    check("prio_second_int", {15'h0, interrupt}, 16'd1);
    check("prio_second_vector", int_vector, 16'h0016);
    pulse_ack();
    pulse_reti();

    // GIE gating and no withdrawal once requesting.
    wr(RB + 16'd2, 16'h0000);
    irq = 4'b0001;
    repeat (4) @(negedge clk);
    irq = '0;
    check("gie_off_no_int", {15'h0, interrupt}, 16'd0);
    rd("gie_off_pending", RB, 16'h0001);
    wr(RB + 16'd2, 16'h0001);
    check("gie_on_not_yet", {15'h0, interrupt}, 16'd0);
    @(negedge clk);
    check("gie_on_int", {15'h0, interrupt}, 16'd1);
    check("gie_on_vector", int_vector, 16'h0010);
    wr(RB + 16'd1, 16'h0000);
    wr(RB, 16'h0001);
    wr(RB + 16'd2, 16'h0000);
    check("no_withdraw", {15'h0, interrupt}, 16'd1);
    pulse_ack();
    check("no_withdraw_ack", {15'h0, interrupt}, 16'd0);
    pulse_reti();

    // W1C colliding with a fresh edge on the same bit.
    irq = 4'b0010;
    repeat (4) @(negedge clk);
    irq = '0;
    repeat (3) @(negedge clk);
    rd("w1c_pre", RB, 16'h0002);
    irq = 4'b0010;
    repeat (2) @(negedge clk);
    wr(RB, 16'h0002);
    rd("w1c_collision", RB, 16'h0002);
    irq = '0;
    repeat (3) @(negedge clk);
    wr(RB, 16'h0002);
    rd("w1c_plain", RB, 16'h0000);

    // Acknowledge colliding with a fresh edge on the active source.
    wr(RB + 16'd1, 16'h000F);
    wr(RB + 16'd2, 16'h0001);
    irq = 4'b0100;
    repeat (4) @(negedge clk);
    check("ackcol_vector", int_vector, 16'h0014);
    irq = '0;
    repeat (3) @(negedge clk);
    irq = 4'b0100;
    repeat (2) @(negedge clk);
    pulse_ack();
    irq = '0;
    rd("ackcol_pending", RB, 16'h0004);
    rd("ackcol_status", RB + 16'd3, 16'h8002);
    pulse_reti();
    check("ackcol_gap", {15'h0, interrupt}, 16'd0);
    @(negedge clk);
    check("ackcol_reraise", {15'h0, interrupt}, 16'd1);
    pulse_ack();
    pulse_reti();

    // Asynchronous reset while requesting.
    irq = 4'b0010;
    repeat (4) @(negedge clk);
    irq = '0;
    check("rst_req_pre", {15'h0, interrupt}, 16'd1);
    rst = 1'b1;
    #1;
    check("rst_req_drop", {15'h0, interrupt}, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) rd($sformatf("rst_reg%0d", i), RB + 16'(i), 16'h0000);

    // Asynchronous reset while in service, with an edge caught in the synchronizer.
    wr(RB + 16'd1, 16'h000F);
    wr(RB + 16'd2, 16'h0001);
    irq = 4'b0001;
    repeat (4) @(negedge clk);
    irq = '0;
    pulse_ack();
    rd("svc_status", RB + 16'd3, 16'h8000);
    irq = 4'b1000;
    @(negedge clk);
    irq = '0;
    rst = 1'b1;
    #1;
    check("rst_svc_int", {15'h0, interrupt}, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    rd("rst_svc_pending", RB, 16'h0000);
    rd("rst_svc_status", RB + 16'd3, 16'h0000);

    // Stray ack and reti in idle.
    pulse_ack();
    pulse_reti();
    check("stray_int", {15'h0, interrupt}, 16'd0);
    rd("stray_status", RB + 16'd3, 16'h0000);

    // Randomized traffic; the reference model checks every cycle.
    for (int c = 0; c < 3000; c++) begin
      int r;
      irq      = irq ^ (4'($urandom) & 4'($urandom) & 4'($urandom));
      io_write = 1'b0;
      io_read  = 1'b0;
      r        = int'($urandom_range(0, 15));
      d_addr   = RB - 16'd1 + 16'($urandom_range(0, 5));
      d_wdata  = 16'($urandom);
      if (r < 2) begin
        io_write = 1'b1;
        if (d_addr == RB + 16'd2) d_wdata[0] = ($urandom_range(0, 3) != 0);
      end else if (r < 6) begin
        io_read = 1'b1;
      end
      int_ack = interrupt ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
      reti    = ($urandom_range(0, 4) == 0);
      @(negedge clk);
    end
    irq = '0; io_write = 1'b0; io_read = 1'b0; int_ack = 1'b0; reti = 1'b0;
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
